dpi_array_responder: RTL
========================

DPI_ARRAY_RESPONDER -- requirements
Module: dpi_array_responder

Interface
REQ-001 The block SHALL have parameter N_MAX, default 4, giving the fixed array length in 32-bit words (legal range 1..255).
REQ-002 The block SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req_valid_i (in, 1), req_ready_o (out, 1), req_func_i (in, 2) and req_n_i (in, 8) forming the call-request channel; req_n_i is the caller's n_elements.
REQ-005 The block SHALL have ports arg_valid_i (in, 1), arg_ready_o (out, 1) and arg_data_i (in, 32) forming the input-array stream, word 0 first.
REQ-006 The block SHALL have ports out_valid_o (out, 1), out_ready_i (in, 1), out_data_o (out, 32) and out_last_o (out, 1) forming the output-array stream, word 0 first.
REQ-007 The block SHALL have ports rsp_valid_o (out, 1), rsp_ready_i (in, 1) and rsp_ret_o (out, 32) forming the return-value channel.
REQ-008 The block SHALL have ports busy_o (out, 1), high whenever state is not IDLE, and calls_o (out, 8), a count of accepted requests.

Function
REQ-009 Every channel SHALL transfer on a cycle where valid and ready are both high; a raised valid SHALL hold with stable data until that transfer.
REQ-010 The FSM SHALL have states IDLE, ARGS, COMPUTE, OUT, RET; req_ready_o SHALL be high only in IDLE, arg_ready_o only in ARGS, out_valid_o only in OUT, and rsp_valid_o only in RET.
REQ-011 On request acceptance the block SHALL latch func, n_eff (see REQ-020) and call_idx = calls_o, then increment calls_o (wrapping 255->0).
REQ-012 For func 1 (SUM), IDLE SHALL go to ARGS; exactly N_MAX words SHALL be consumed whatever n is; words with index < n_eff SHALL be added modulo 2^32 into an accumulator cleared at acceptance; after the last beat ARGS SHALL go to COMPUTE.
REQ-013 For func 0 (FILL), IDLE SHALL go to COMPUTE, then OUT; exactly N_MAX words SHALL be emitted; word i SHALL be {16'hF111, call_idx[7:0], i[7:0]} for i < n_eff and 0 otherwise; out_last_o SHALL be high only on word N_MAX-1; after the last transfer OUT SHALL go to RET.
REQ-014 For func 2 or 3, IDLE SHALL go to COMPUTE, then RET with rsp_ret_o = 32'hFFFF_FFFF, without consuming or emitting array words.
REQ-015 COMPUTE SHALL last exactly one cycle; SUM SHALL go from COMPUTE to RET.
REQ-016 rsp_ret_o SHALL be the 32-bit sum for SUM and n_eff zero-extended for FILL; after the RET transfer the FSM SHALL go to IDLE, so the next request can be accepted the following cycle.
REQ-017 Minimum latency with all ready signals high SHALL be: FILL first out word valid 2 cycles after acceptance; SUM rsp_valid_o 2 cycles after the last arg beat.
REQ-018 With n = 0, SUM SHALL return 0 and FILL SHALL emit N_MAX zero words and return 0.
REQ-019 All outputs SHALL be driven from registers; arg_data_i SHALL be ignored outside ARGS.

Configuration
REQ-020 With macro DPI_ARRAY_RESP_CLAMP_EN defined, n_eff SHALL be min(req_n_i, N_MAX); without it, a request with req_n_i > N_MAX SHALL set n_eff = 0, and for func 0/1 the return value SHALL be 32'hFFFF_FFFF; SUM still consumes N_MAX words and FILL still emits N_MAX zero words, keeping the streams aligned.

Reset
REQ-021 Asserting rst_ni low at any time, including mid-ARGS or mid-OUT, SHALL immediately force IDLE, calls_o = 0, accumulator = 0, and out_valid_o, rsp_valid_o, arg_ready_o and busy_o = 0, with req_ready_o = 1, out_data_o = 0, out_last_o = 0 and rsp_ret_o = 0.
REQ-022 After rst_ni rises, the first request SHALL be accepted no earlier than the first rising edge with rst_ni high.

Verification
REQ-023 After reset, SUM n=4 with args 9ABCDEF0, 12345678, CAFEBABE, DEADBEEF SHALL give rsp_ret_o = 569DAF15 and calls_o = 1.
REQ-024 The next request, FILL n=4 (call_idx 1), SHALL emit F1110100..F1110103 with out_last_o only on the 4th word, then ret = 4; SUM n=4 of those words SHALL then return C4440406.
REQ-025 FILL n=2 as the first call after reset SHALL emit F1110000, F1110001, 0, 0 and return 2.
REQ-026 SUM with req_n_i = 9 and N_MAX = 4, args 1, 2, 3, 4, SHALL return 0000000A with DPI_ARRAY_RESP_CLAMP_EN defined and FFFFFFFF without it; both cases consume 4 beats.
REQ-027 Randomly stall out_ready_i and rsp_ready_i -> data and valids stay stable until each transfer; func 3 returns FFFFFFFF with no stream beats.
REQ-028 Pulse rst_ni low after the 2nd arg beat of a SUM -> all valids drop the same cycle; a fresh SUM n=1 with arg 5 then returns 5, with call_idx restarting at 0.

Source files
------------

// File: rtl/dpi_array_responder.sv
// Hardware responder for an array-passing call: SUM consumes an input array, FILL emits one.
// Optional macro DPI_ARRAY_RESP_CLAMP_EN clamps n to N_MAX instead of flagging an oversized n.
module dpi_array_responder #(
   parameter int N_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_func_i,
   input  logic [7:0]  req_n_i,
   input  logic        arg_valid_i,
   output logic        arg_ready_o,
   input  logic [31:0] arg_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic        out_last_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_ret_o,
   output logic        busy_o,
   output logic [7:0]  calls_o
);

   typedef enum logic [2:0] {IDLE, ARGS, COMPUTE, OUT, RET} state_t;
   localparam logic [1:0] FN_FILL = 2'd0;
   localparam logic [1:0] FN_SUM  = 2'd1;
   localparam logic [7:0] N_MAX8  = 8'(N_MAX);
   localparam logic [7:0] N_LAST  = 8'(N_MAX - 1);

   state_t      state;
   logic [1:0]  func;
   logic [7:0]  n_eff;
   logic [7:0]  call_idx;
   logic [7:0]  idx;
   logic        ovf;
   logic [31:0] acc;

   logic [7:0]  req_n_eff;
   logic        req_ovf;
   logic [31:0] ret_val;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      req_n_eff = req_n_i;
      req_ovf   = 1'b0;
      if (req_n_i > N_MAX8) begin
`ifdef DPI_ARRAY_RESP_CLAMP_EN
         req_n_eff = N_MAX8;
`else
         req_n_eff = 8'd0;
         req_ovf   = 1'b1;
`endif
      end
   end

   always_comb begin
      ret_val = 32'hFFFF_FFFF;
      if (!func[1] && !ovf) ret_val = (func == FN_SUM) ? acc : {24'd0, n_eff};
   end

   // Words past n_eff are padded with zero so the stream length is always N_MAX.
   function automatic logic [31:0] fill_word(input logic [7:0] i, input logic [7:0] n,
                                             input logic [7:0] cidx);
      return (i < n) ? {16'hF111, cidx, i} : 32'd0;
   endfunction

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: data registers are reset too, because the output values after reset are observable.
         state       <= IDLE;
         func        <= FN_FILL;
         n_eff       <= 8'd0;
         call_idx    <= 8'd0;
         idx         <= 8'd0;
         ovf         <= 1'b0;
         acc         <= 32'd0;
         req_ready_o <= 1'b1;
         arg_ready_o <= 1'b0;
         out_valid_o <= 1'b0;
         out_data_o  <= 32'd0;
         out_last_o  <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_ret_o   <= 32'd0;
         busy_o      <= 1'b0;
         calls_o     <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  func        <= req_func_i;
                  n_eff       <= req_n_eff;
                  ovf         <= req_ovf;
                  call_idx    <= calls_o;
                  calls_o     <= calls_o + 8'd1;
                  acc         <= 32'd0;
                  idx         <= 8'd0;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  if (req_func_i == FN_SUM) begin
                     state       <= ARGS;
                     arg_ready_o <= 1'b1;
                  end else begin
                     state <= COMPUTE;
                  end
               end
            end
            ARGS: begin
               if (arg_valid_i) begin
                  if (idx < n_eff) acc <= acc + arg_data_i;
                  if (idx == N_LAST) begin
                     state       <= COMPUTE;
                     arg_ready_o <= 1'b0;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            COMPUTE: begin
               if (func == FN_FILL) begin
                  state       <= OUT;
                  out_valid_o <= 1'b1;
                  out_data_o  <= fill_word(8'd0, n_eff, call_idx);
                  out_last_o  <= (N_LAST == 8'd0);
               end else begin
                  state       <= RET;
                  rsp_valid_o <= 1'b1;
                  rsp_ret_o   <= ret_val;
               end
            end
            OUT: begin
               if (out_ready_i) begin
                  if (idx == N_LAST) begin
                     state       <= RET;
                     out_valid_o <= 1'b0;
                     out_data_o  <= 32'd0;
                     out_last_o  <= 1'b0;
                     rsp_valid_o <= 1'b1;
                     rsp_ret_o   <= ret_val;
                  end else begin
                     idx        <= idx + 8'd1;
                     out_data_o <= fill_word(idx + 8'd1, n_eff, call_idx);
                     out_last_o <= ((idx + 8'd1) == N_LAST);
                  end
               end
            end
            RET: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  rsp_ret_o   <= 32'd0;
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
